// File: rtl/de_board_pkg.sv
// Board-level constants shared by the DE-series input conditioning logic.
// Pushbuttons are active-low, so a pressed key reads as 0.
package de_board_pkg;

  localparam logic KEY_PRESSED  = 1'b0;
  localparam logic KEY_RELEASED = 1'b1;

  // 10 ms of stable input at 50 MHz
  localparam int unsigned DEBOUNCE_10MS_50MHZ = 500000;

endpackage

// File: rtl/key_debounce_bit.sv
// Conditions one pushbuttonx: a 2-FF synchroniser, a stability counter, and registered
// press/release strobes that line up with the accepted level change.
module key_debounce_bit
  import de_board_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_10MS_50MHZ,
  parameter int unsigned CNT_W           = $clog2(DEBOUNCE_CYCLES + 1)
) (
  input  logic CLOCK_50,
  input  logic Reset,
  input  logic i_raw,
  output logic o_clean,
  output logic o_press,
  output logic o_release
);

  localparam logic [CNT_W-1:0] CntLast = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             r_s1;
  logic             r_s2;
  logic [CNT_W-1:0] r_cnt;
  logic             r_clean;
  logic             r_press;
  logic             r_release;

  always_ff @(posedge CLOCK_50 or posedge Reset) begin
    if (Reset) begin
      r_s1      <= KEY_RELEASED;
      r_s2      <= KEY_RELEASED;
      r_cnt     <= '0;
      r_clean   <= KEY_RELEASED;
      r_press   <= 1'b0;
      r_release <= 1'b0;
    end else begin
      r_s1      <= i_raw;
      r_s2      <= r_s1;
      r_press   <= 1'b0;
      r_release <= 1'b0;
      if (r_s2 == r_clean) begin
        // Any return to the accepted level discards the partial count.
        r_cnt <= '0;
      end else if (r_cnt == CntLast) begin
        r_clean   <= r_s2;
        r_cnt     <= '0;
        r_press   <= (r_s2 == KEY_PRESSED);
        r_release <= (r_s2 == KEY_RELEASED);
      end else begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
    end
  end

  assign o_clean   = r_clean;
  assign o_press   = r_press;
  assign o_release = r_release;

endmodule

// File: rtl/key_debounce.sv
// Debounces N_KEYS independent active-low pushbuttons; each key gets its own
// synchroniser and counter, so strobes on different keys may coincide.
module key_debounce
  import de_board_pkg::*;
#(
  parameter int unsigned N_KEYS          = 2,
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_10MS_50MHZ,
  parameter int unsigned CNT_W           = $clog2(DEBOUNCE_CYCLES + 1)
) (
  input  logic              CLOCK_50,
  input  logic              Reset,
  input  logic [N_KEYS-1:0] KEY_raw,
  output logic [N_KEYS-1:0] KEY_clean,
  output logic [N_KEYS-1:0] Press,
  output logic [N_KEYS-1:0] Release
);

  for (genvar g = 0; g < N_KEYS; g++) begin : g_key
    key_debounce_bit #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .CNT_W          (CNT_W)
    ) u_bit (
      .CLOCK_50 (CLOCK_50),
      .Reset    (Reset),
      .i_raw    (KEY_raw[g]),
      .o_clean  (KEY_clean[g]),
      .o_press  (Press[g]),
      .o_release(Release[g])
    );
  end

endmodule
